mux21_rr_arbiter: RTL and testbench
===================================

# mux21_rr_arbiter

Two-requester round-robin arbiter that shares one 2:1 multiplexer channel between two sources. It owns the mux select: it issues a grant to one requester at a time, drives the select line, and registers the selected data word onto a single output with a valid flag. It sits in front of the MUX_21 datapath and replaces the static select with a fair, time-limited schedule.

## Interface
- `DATA_W`, default 8: width of each data input and of the output.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other requester waits. Legal range 1..255.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req1`  in  1  requester 1 level request.
- `req2`  in  1  requester 2 level request.
- `in1`  in  DATA_W  requester 1 data.
- `in2`  in  DATA_W  requester 2 data.
- `gnt1`  out  1  grant to requester 1; registered.
- `gnt2`  out  1  grant to requester 2; registered.
- `sel`  out  1  mux select: 0 selects `in1`, 1 selects `in2`; registered.
- `out`  out  DATA_W  registered selected data.
- `out_valid`  out  1  `out` holds a granted word.

## Operation
- States are IDLE, G1 and G2. `gnt1` = (state==G1) and `gnt2` = (state==G2); the two are never high together.
- `last` records the last requester served (1 or 2). `hold` is the grant-cycle counter, `$clog2(MAX_HOLD+1)` bits wide.
- Reset values: state IDLE, `gnt1`=`gnt2`=0, `sel`=0, `last`=2 (so requester 1 wins the first tie), `hold`=0, `out`=0, `out_valid`=0.
- IDLE transitions:
  - `req1` & `req2`: go to G2 if `last`==1, else G1.
  - Only `req1`: go to G1.
  - Only `req2`: go to G2.
  - Neither: stay in IDLE.
- Gx transitions (x = own requester, y = other):
  - If `reqx`==0: go to Gy if `reqy`, else IDLE.
  - Else if `reqy` and `hold`==MAX_HOLD-1: go to Gy (forced rotation).
  - Else stay in Gx, with `hold` = min(`hold`+1, MAX_HOLD-1).
- Entering any grant state:
  - `hold` ← 0.
  - `last` ← the requester granted.
  - `sel` ← 0 for G1, 1 for G2.
- Grant handoff G1↔G2 has no IDLE bubble.
- In IDLE, `sel` keeps its last value and `hold` stays at 0.
- Data path, every edge:
  - `out_valid` ← (state==G1 | state==G2), using the pre-edge state.
  - `out` ← `in1` if the pre-edge state is G1, `in2` if G2, else holds.
- Because `hold` saturates, a lone requester keeps its grant indefinitely. Rotation happens on the first edge where the other requester is high and `hold`==MAX_HOLD-1.
- MAX_HOLD=1: with both requesting, grants alternate every cycle.

## Timing
- Request to grant: a request first sampled high at edge N gives `gnt`/`sel` valid after edge N.
- Grant to data: `out` and `out_valid` follow one cycle later, after edge N+1, carrying the input value sampled at edge N+1.
- Release: `reqx` dropping before edge M deasserts `gntx` after edge M. The final `out_valid` pulse follows after edge M, carrying the data sampled at M.
- Requests are level-sensitive. A requester must hold `req` until it sees its grant. A request that drops before being granted is lost, and no state changes.
- Simultaneous release and other request: direct handoff, and `out_valid` stays high continuously.
- Reset asserted mid-grant forces every output to its reset value immediately, with no clock. After deassertion, operation restarts from IDLE with `last`=2.

## Test plan
- Reset, then `req1`=1 only, `in1`=0xA5, MAX_HOLD=4 → `gnt1`=1 and `sel`=0 after the first edge. On the next edge `out`=0xA5, `out_valid`=1. `gnt2` stays 0 throughout.
- From IDLE, `req1`=`req2`=1 in the same cycle → `gnt1` first. With both held, the grant stays on requester 1 for exactly 4 cycles, then `gnt2`/`sel`=1 for 4 cycles, alternating, with `out` switching between `in1`=0x11 and `in2`=0x22 one cycle after `sel`.
- Grant on requester 2, `req2` drops while `req1`=1 → `gnt1` the next cycle with no idle cycle. `out_valid` stays 1, and `out` changes from `in2` to `in1` data one cycle after `sel`.
- `req2` alone for 10 cycles → `gnt2` held all 10 cycles and `hold` saturates at 3. Raise `req1` → `gnt1` after the next edge.
- Assert `rst` asynchronously mid-grant (between edges) → `gnt1`=`gnt2`=`sel`=`out_valid`=0 and `out`=0 before the next edge. After release with both requesting, requester 1 is granted first.
- MAX_HOLD=1, both requesting → `sel` toggles every cycle: 0,1,0,1.

Source files
------------

// File: rtl/mux21_rr_arbiter_if.sv
// Handshake and data bundle between the two requesters and the
// round-robin arbiter. The arbiter takes the slave side.
interface mux21_rr_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              req1;
   logic              req2;
   logic [DATA_W-1:0] in1;
   logic [DATA_W-1:0] in2;
   logic              gnt1;
   logic              gnt2;
   logic              sel;
   logic [DATA_W-1:0] out;
   logic              out_valid;

   modport master (
      output req1, req2, in1, in2,
      input  gnt1, gnt2, sel, out, out_valid
   );

   modport slave (
      input  req1, req2, in1, in2,
      output gnt1, gnt2, sel, out, out_valid
   );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// Two-requester round-robin arbiter owning the select of a 2:1 mux.
// Grants one requester at a time, limits a contested grant to MAX_HOLD
// cycles, and registers the selected word with a valid flag.
//
// state | meaning
// IDLE  | no grant; sel holds its last value, hold is 0
// G1    | requester 1 granted, sel = 0
// G2    | requester 2 granted, sel = 1
module mux21_rr_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input logic               clk,
   input logic               rst,
   mux21_rr_arbiter_if.slave bus
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G1   = 2'd1,
      G2   = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [HOLD_W-1:0]   hold_q;
   logic [HOLD_W-1:0]   hold_d;
   // last_is2 = 1 means requester 2 was served last; reset gives the first
   // tie to requester 1.
   logic                last_is2_q;
   logic                last_is2_d;
   logic                sel_q;
   logic                sel_d;
   logic [DATA_W-1:0]   out_q;
   logic                valid_q;

   // Next-state, hold counter, select and last-served decision.
   always_comb begin
      state_d    = state_q;
      hold_d     = '0;
      last_is2_d = last_is2_q;
      sel_d      = sel_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req1 && bus.req2) state_d = last_is2_q ? G1 : G2;
            else if (bus.req1)        state_d = G1;
            else if (bus.req2)        state_d = G2;
         end
         G1: begin
            if (!bus.req1)                              state_d = bus.req2 ? G2 : IDLE;
            else if (bus.req2 && (hold_q == HOLD_TOP))  state_d = G2;
         end
         G2: begin
            if (!bus.req2)                              state_d = bus.req1 ? G1 : IDLE;
            else if (bus.req1 && (hold_q == HOLD_TOP))  state_d = G1;
         end
         default: state_d = IDLE;
      endcase

      // Staying in a grant counts up and saturates so a lone requester
      // keeps its grant; entering a grant or idling clears the count.
      if ((state_d != IDLE) && (state_d == state_q)) begin
         hold_d = (hold_q == HOLD_TOP) ? hold_q : hold_q + HOLD_W'(1);
      end

      if (state_d == G1) begin
         sel_d      = 1'b0;
         last_is2_d = 1'b0;
      end else if (state_d == G2) begin
         sel_d      = 1'b1;
         last_is2_d = 1'b1;
      end
   end

   // Control registers: grant state, hold counter, last served, select.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         last_is2_q <= 1'b1;
         sel_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         last_is2_q <= last_is2_d;
         sel_q      <= sel_d;
      end
   end

   // Data path: capture the word of whoever held the grant before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state_q == G1) || (state_q == G2);
         if (state_q == G1)      out_q <= bus.in1;
         else if (state_q == G2) out_q <= bus.in2;
      end
   end

   assign bus.gnt1      = (state_q == G1);
   assign bus.gnt2      = (state_q == G2);
   assign bus.sel       = sel_q;
   assign bus.out       = out_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Directed bench for mux21_rr_arbiter: expected output vectors
// {gnt1,gnt2,sel,out_valid,out} are queued as stimulus is driven and
// popped after the following clock edge.
module tb_mux21_rr_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mux21_rr_arbiter_if #(.DATA_W(8)) bus4 ();
   mux21_rr_arbiter_if #(.DATA_W(8)) bus1 ();

   mux21_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) u4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   mux21_rr_arbiter #(.DATA_W(8), .MAX_HOLD(1)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          unit;
      logic [11:0] vec;
   } exp_t;

   exp_t sbq[$];

   function automatic logic [11:0] obs(int unit);
      if (unit == 1) return {bus1.gnt1, bus1.gnt2, bus1.sel, bus1.out_valid, bus1.out};
      return {bus4.gnt1, bus4.gnt2, bus4.sel, bus4.out_valid, bus4.out};
   endfunction

   task automatic check(string tag, logic [11:0] o, logic [11:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic expect_next(int unit, logic g1, logic g2, logic s, logic v, logic [7:0] d);
      exp_t e;
      e.unit = unit;
      e.vec  = {g1, g2, s, v, d};
      sbq.push_back(e);
   endtask

   task automatic tick(string tag);
      exp_t e;
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check(tag, obs(e.unit), e.vec);
      end
   endtask

   task automatic do_reset();
      bus4.req1 = 1'b0; bus4.req2 = 1'b0;
      bus1.req1 = 1'b0; bus1.req2 = 1'b0;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("reset_u4", obs(4), 12'h000);
      check("reset_u1", obs(1), 12'h000);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      bus4.in1 = 8'h00; bus4.in2 = 8'h00;
      bus1.in1 = 8'h00; bus1.in2 = 8'h00;

      // Lone requester 1: grant, then data one cycle later, then release.
      do_reset();
      bus4.req1 = 1'b1; bus4.in1 = 8'hA5;
      expect_next(4, 1, 0, 0, 0, 8'h00); tick("lone1_grant");
      expect_next(4, 1, 0, 0, 1, 8'hA5); tick("lone1_data");
      bus4.req1 = 1'b0;
      expect_next(4, 0, 0, 0, 1, 8'hA5); tick("lone1_release");
      expect_next(4, 0, 0, 0, 0, 8'hA5); tick("lone1_idle");

      // Both requesting from reset: 4-cycle slots alternating, requester 1 first.
      do_reset();
      bus4.req1 = 1'b1; bus4.req2 = 1'b1; bus4.in1 = 8'h11; bus4.in2 = 8'h22;
      for (int k = 1; k <= 12; k++) begin
         int          own;
         int          prev;
         logic [7:0]  d;
         own  = ((k - 1) / 4) % 2;
         prev = (k >= 2) ? ((k - 2) / 4) % 2 : 0;
         d    = (k == 1) ? 8'h00 : ((prev == 0) ? 8'h11 : 8'h22);
         expect_next(4, (own == 0), (own == 1), (own == 1), (k > 1), d);
         tick("both_rotate");
      end

      // Requester 2 releases while 1 waits: direct handoff, valid stays high.
      do_reset();
      bus4.req2 = 1'b1; bus4.in2 = 8'h44; bus4.in1 = 8'h33;
      expect_next(4, 0, 1, 1, 0, 8'h00); tick("handoff_g2");
      expect_next(4, 0, 1, 1, 1, 8'h44); tick("handoff_g2_data");
      bus4.req2 = 1'b0; bus4.req1 = 1'b1;
      expect_next(4, 1, 0, 0, 1, 8'h44); tick("handoff_to_g1");
      expect_next(4, 1, 0, 0, 1, 8'h33); tick("handoff_g1_data");

      // Lone requester 2 for 10 cycles: hold saturates, then requester 1 rotates in.
      do_reset();
      bus4.req2 = 1'b1; bus4.in2 = 8'h5A; bus4.in1 = 8'hC3;
      for (int k = 1; k <= 10; k++) begin
         expect_next(4, 0, 1, 1, (k > 1), (k > 1) ? 8'h5A : 8'h00);
         tick("lone2_hold");
         check("hold_count", 12'(u4.hold_q), 12'((k - 1 > 3) ? 3 : k - 1));
      end
      bus4.req1 = 1'b1;
      expect_next(4, 1, 0, 0, 1, 8'h5A); tick("lone2_then_req1");
      expect_next(4, 1, 0, 0, 1, 8'hC3); tick("req1_data");

      // Asynchronous reset in the middle of the G1 grant.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_reset", obs(4), 12'h000);
      bus4.req1 = 1'b1; bus4.req2 = 1'b1; bus4.in1 = 8'h77; bus4.in2 = 8'h88;
      @(negedge clk);
      rst = 1'b0;
      expect_next(4, 1, 0, 0, 0, 8'h00); tick("post_reset_tie");
      expect_next(4, 1, 0, 0, 1, 8'h77); tick("post_reset_data");

      // MAX_HOLD=1 with both requesting: select toggles every cycle.
      do_reset();
      bus1.req1 = 1'b1; bus1.req2 = 1'b1; bus1.in1 = 8'h11; bus1.in2 = 8'h22;
      for (int k = 1; k <= 4; k++) begin
         logic       s;
         logic [7:0] d;
         s = ((k - 1) % 2) == 1;
         d = (k == 1) ? 8'h00 : (((k - 2) % 2 == 0) ? 8'h11 : 8'h22);
         expect_next(1, !s, s, s, (k > 1), d);
         tick("maxhold1_toggle");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
